// File: rtl/ocd_cmd_sequencer.sv
// Byte-stream command sequencer driving the MCU on-chip-debug memory port and core start.
// Optional read-wait timeout is enabled with the OCD_TIMEOUT_EN macro.
module ocd_cmd_sequencer #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned XLEN      = 32
`ifdef OCD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 ocd_read_enable,
  output logic                 ocd_write_enable,
  output logic [ADDR_BITS-1:0] ocd_rw_addr,
  output logic [XLEN-1:0]      ocd_write_word,
  input  logic                 ocd_mem_enable_out,
  input  logic [XLEN-1:0]      ocd_mem_word_out,
  input  logic                 processor_paused,
  output logic                 start,
  output logic [XLEN-1:0]      start_address,
  output logic                 busy
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [XLEN-1:0] START_RESET = XLEN'(32'h8000_0000);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CHK, S_WDATA, S_WSTB, S_RREQ,
    S_RWAIT, S_RSEND, S_DRAIN, S_GO, S_ACK, S_NAK
  } state_e;

  state_e state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [47:0]          hdr_q, hdr_d;
  logic [15:0]          len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [XLEN-1:0]      wword_q, wword_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 drain_q, drain_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 start_q, start_d;
  logic [XLEN-1:0]      start_addr_q, start_addr_d;
  logic                 busy_q, busy_d;
  logic                 rx_fire;
  logic [31:0]          hdr_addr;
  logic [15:0]          hdr_len;

`ifdef OCD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign rx_fire  = rx_valid & rx_ready_q;
  assign hdr_addr = hdr_q[47:16];
  assign hdr_len  = hdr_q[15:0];

  // Next-state and datapath for the frame parser / memory sequencer
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    len_d        = len_q;
    addr_d       = addr_q;
    wword_d      = wword_q;
    rdata_d      = rdata_q;
    drain_d      = drain_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    start_d      = 1'b0;
    start_addr_d = start_addr_q;
`ifdef OCD_TIMEOUT_EN
    tmo_d        = '0;
`endif

    case (state_q)
      S_IDLE: begin
        drain_d = 1'b0;
        if (rx_fire) begin
          cmd_d = rx_data;
          cnt_d = 3'd0;
          if (rx_data == CMD_W || rx_data == CMD_R || rx_data == CMD_G) state_d = S_HDR;
          else state_d = S_NAK;
        end
      end
      S_HDR: begin
        if (rx_fire) begin
          hdr_d = {hdr_q[39:0], rx_data};
          if (cnt_q == 3'd5) begin
            cnt_d   = 3'd0;
            state_d = S_CHK;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_CHK: begin
        len_d  = hdr_len;
        addr_d = hdr_addr[ADDR_BITS+1:2];
        if (cmd_q == CMD_G) state_d = S_GO;
        else if (!processor_paused) begin
          state_d = S_NAK;
          drain_d = (cmd_q == CMD_W) && (hdr_len != 16'd0);
        end
        else if (hdr_len == 16'd0) state_d = S_ACK;
        else if (cmd_q == CMD_W) state_d = S_WDATA;
        else state_d = S_RREQ;
      end
      S_WDATA: begin
        if (rx_fire) begin
          wword_d = {wword_q[XLEN-9:0], rx_data};
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_WSTB;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_WSTB: begin
        addr_d  = addr_q + ADDR_BITS'(1);
        len_d   = len_q - 16'd1;
        state_d = (len_q == 16'd1) ? S_ACK : S_WDATA;
      end
      S_RREQ: state_d = S_RWAIT;
      S_RWAIT: begin
        if (ocd_mem_enable_out) begin
          rdata_d = ocd_mem_word_out;
          cnt_d   = 3'd0;
          state_d = S_RSEND;
        end
`ifdef OCD_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) state_d = S_NAK;
        else tmo_d = tmo_q + TMO_W'(1);
`endif
      end
      S_RSEND: begin
        // Each byte is presented, then retired on handshake; data shifts MSB first
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = rdata_q[XLEN-1 -: 8];
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          rdata_d    = {rdata_q[XLEN-9:0], 8'h00};
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            addr_d  = addr_q + ADDR_BITS'(1);
            len_d   = len_q - 16'd1;
            state_d = (len_q == 16'd1) ? S_ACK : S_RREQ;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if (rx_fire) begin
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            len_d = len_q - 16'd1;
            if (len_q == 16'd1) state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_GO: begin
        start_addr_d = XLEN'(hdr_addr);
        start_d      = 1'b1;
        state_d      = S_ACK;
      end
      S_ACK, S_NAK: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = (state_q == S_ACK) ? ACK_BYTE : NAK_BYTE;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          cnt_d      = 3'd0;
          state_d    = (state_q == S_NAK && drain_q) ? S_DRAIN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE) || (state_d == S_HDR) ||
                 (state_d == S_WDATA) || (state_d == S_DRAIN);
    busy_d     = (state_d != S_IDLE);
    rd_en_d    = (state_d == S_RREQ);
    wr_en_d    = (state_d == S_WSTB);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      hdr_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      wword_q      <= '0;
      rdata_q      <= '0;
      drain_q      <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rx_ready_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      start_q      <= 1'b0;
      start_addr_q <= START_RESET;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wword_q      <= wword_d;
      rdata_q      <= rdata_d;
      drain_q      <= drain_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      rx_ready_q   <= rx_ready_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      start_q      <= start_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
    end
  end

`ifdef OCD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  assign rx_ready         = rx_ready_q;
  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign ocd_read_enable  = rd_en_q;
  assign ocd_write_enable = wr_en_q;
  assign ocd_rw_addr      = addr_q;
  assign ocd_write_word   = wword_q;
  assign start            = start_q;
  assign start_address    = start_addr_q;
  assign busy             = busy_q;

endmodule
